// File: rtl/press_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : press_event_pkg
// Description : State encoding and default timing constants for the press
//               event classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package press_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED1  = 3'd1,
        ST_WAIT_GAP  = 3'd2,
        ST_PRESSED2  = 3'd3,
        ST_LONG_HELD = 3'd4
    } state_t;

    localparam int DEF_LONG_CYCLES = 8;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_TIMER_W     = 8;

endpackage : press_event_pkg
`default_nettype wire

// File: rtl/press_event_classifier_sat_state_timer.sv
`default_nettype none
// ============================================================================
// Module      : sat_state_timer
// Description : Saturating per-state cycle counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_state_timer
    import press_event_pkg::*;
#(
    parameter int WIDTH = DEF_TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count != {WIDTH{1'b1}}) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_state_timer
`default_nettype wire

// File: rtl/press_event_classifier.sv
`default_nettype none
// ============================================================================
// Module      : press_event_classifier
// Description : Classifies debounced button gestures into short, long and
//               double presses, emitting one registered pulse per gesture.
// Revision    : 1.0 - initial release
// ============================================================================
module press_event_classifier
    import press_event_pkg::*;
#(
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int TIMER_W     = DEF_TIMER_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic busy
);

    localparam int               c_timer_max = (2 ** TIMER_W) - 1;
    localparam logic [TIMER_W-1:0] c_long_last = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_gap_last  = TIMER_W'(GAP_CYCLES - 1);

    generate
        if (LONG_CYCLES < 2 || LONG_CYCLES > c_timer_max ||
            GAP_CYCLES < 2 || GAP_CYCLES > c_timer_max) begin : g_bad_params
            $error("press_event_classifier: LONG_CYCLES/GAP_CYCLES out of range for TIMER_W");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic [TIMER_W-1:0] w_timer;
    logic               w_timer_clear;
    logic               w_short_set;
    logic               w_long_set;
    logic               w_double_set;
    logic               r_short_press;
    logic               r_long_press;
    logic               r_double_press;
    logic               r_busy;

    // Any state change restarts the timer so each state measures its own dwell.
    assign w_timer_clear = (r_state != w_next_state);

    sat_state_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_timer_clear),
        .count (w_timer)
    );

    always_comb begin
        w_next_state = r_state;
        w_short_set  = 1'b0;
        w_long_set   = 1'b0;
        w_double_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn_in) w_next_state = ST_PRESSED1;
            end
            ST_PRESSED1: begin
                if (!btn_in) begin
                    w_next_state = ST_WAIT_GAP;
                end else if (w_timer == c_long_last) begin
                    w_next_state = ST_LONG_HELD;
                    w_long_set   = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (!btn_in) w_next_state = ST_IDLE;
            end
            ST_WAIT_GAP: begin
                // A second press wins even on the final gap cycle.
                if (btn_in) begin
                    w_next_state = ST_PRESSED2;
                end else if (w_timer == c_gap_last) begin
                    w_next_state = ST_IDLE;
                    w_short_set  = 1'b1;
                end
            end
            ST_PRESSED2: begin
                if (!btn_in) begin
                    w_next_state = ST_IDLE;
                    w_double_set = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_short_press  <= 1'b0;
            r_long_press   <= 1'b0;
            r_double_press <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_short_press  <= w_short_set;
            r_long_press   <= w_long_set;
            r_double_press <= w_double_set;
            r_busy         <= (w_next_state != ST_IDLE);
        end
    end

    assign short_press  = r_short_press;
    assign long_press   = r_long_press;
    assign double_press = r_double_press;
    assign busy         = r_busy;

endmodule : press_event_classifier
`default_nettype wire
